// File: rtl/uo_log_pkg.sv
// Shared types and helpers for the uo_out change logger.
// REC_W / uo_rec_t describe the default record layout {ts, value}, timestamp in the MSBs.
// fifo_ptr_w gives the pointer width for a power-of-2 FIFO depth (minimum 1 bit).
package uo_log_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned TS_W   = 16;
  localparam int unsigned REC_W  = TS_W + DATA_W;

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] value;
  } uo_rec_t;

  function automatic int unsigned fifo_ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/uo_log_fifo.sv
// Show-ahead FIFO with synchronous active-high reset.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, pop     write request, read request (pop ignored while empty)
//   wr_data       record to store
//   rd_data_c     head record, combinational from mem[rd_ptr]
//   count         registered occupancy
//   full_c/empty_c  derived from count
//   push_acc_c    push accepted this cycle (not full, or full with a simultaneous pop)
module uo_log_fifo
  import uo_log_pkg::*;
#(
  parameter int unsigned W     = REC_W,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wr_data,
  output logic [W-1:0]     rd_data_c,
  output logic [CNT_W-1:0] count,
  output logic             full_c,
  output logic             empty_c,
  output logic             push_acc_c
);

  localparam int unsigned PTR_W = fifo_ptr_w(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_acc_c;

  // Accept/advance logic; a full FIFO still takes a push when a pop frees a slot
  always_comb begin
    full_c     = (count_q == CNT_W'(DEPTH));
    empty_c    = (count_q == '0);
    pop_acc_c  = pop && !empty_c;
    push_acc_c = push && (!full_c || pop_acc_c);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_acc_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_acc_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_acc_c, pop_acc_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible while count is nonzero
  always_ff @(posedge clk) begin
    if (push_acc_c) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data_c = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/uo_change_logger.sv
// Capture stage for a microtile's uo_out bus: synchronises the bus, logs every
// value change as a {ts, value} record into a show-ahead FIFO, and tracks drops.
// Optional build macro UO_LOG_TS_DELTA_EN: ts field holds cycles since the previous
// accepted event (saturating) instead of the absolute wrapping timestamp.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   uo_in       asynchronous tile output bus
//   enable      gates change detection (tracking register always follows the bus)
//   rd_ready    consumer accepts head record
//   rd_valid    FIFO non-empty
//   rd_data     head record {ts, value}
//   count       FIFO occupancy
//   overflow    sticky drop flag
//   drop_cnt    saturating dropped-event counter
//   clear_ovf   clears overflow and drop_cnt (a same-cycle drop wins)
module uo_change_logger
  import uo_log_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DROP_W = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      uo_in,
  input  logic                   enable,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [TS_W+DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]       count,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt,
  input  logic                   clear_ovf
);

  localparam int unsigned LREC_W = TS_W + DATA_W;

  logic [DATA_W-1:0] s1_q, s1_d;
  logic [DATA_W-1:0] s2_q, s2_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [TS_W-1:0]   ts_field_c;
  logic              evt_c, pop_c, drop_c;
  logic              push_acc_c, full_c, empty_c;
  logic [LREC_W-1:0] wr_rec_c;

  // Synchroniser, change detect and overflow bookkeeping
  always_comb begin
    s1_d     = uo_in;
    s2_d     = s1_q;
    prev_d   = s2_q;
    evt_c    = enable && (s2_q != prev_q);
    pop_c    = rd_valid && rd_ready;
    drop_c   = evt_c && !push_acc_c;
    wr_rec_c = {ts_field_c, s2_q};
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (clear_ovf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
    if (drop_c) begin
      ovf_d  = 1'b1;
      if (clear_ovf)     drop_d = DROP_W'(1);
      else if (&drop_q)  drop_d = drop_q;
      else               drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

`ifdef UO_LOG_TS_DELTA_EN
  logic [TS_W-1:0] delta_q, delta_d;

  // Elapsed-cycle counter; restarts only when a record is actually stored
  always_comb begin
    delta_d    = (&delta_q) ? delta_q : delta_q + TS_W'(1);
    if (push_acc_c) delta_d = '0;
    ts_field_c = delta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) delta_q <= '0;
    else     delta_q <= delta_d;
  end
`else
  logic [TS_W-1:0] ts_q, ts_d;

  // Free-running wrapping timestamp
  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    ts_field_c = ts_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_d;
  end
`endif

  uo_log_fifo #(
    .W     (LREC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (evt_c),
    .pop        (pop_c),
    .wr_data    (wr_rec_c),
    .rd_data_c  (rd_data),
    .count      (count),
    .full_c     (full_c),
    .empty_c    (empty_c),
    .push_acc_c (push_acc_c)
  );

  assign rd_valid = !empty_c;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: doc/uo_change_logger.md
Name: uo_change_logger

Overview:
- Downstream capture stage for a microtile's 8-bit uo_out bus.
- Synchronises the bus into the logger clock domain and detects any change in value.
- Each change is pushed as a {timestamp, value} record into a small show-ahead FIFO.
- A bench or host drains the FIFO over a ready/valid port; overflow is sticky and counted.

Parameters:
- DATA_W, 8: width of the monitored bus.
- TS_W, 16: width of the free-running timestamp counter and the stored timestamp.
- DEPTH, 8: FIFO entries; must be a power of 2, minimum 2.
- DROP_W, 8: width of the saturating dropped-event counter.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- uo_in  in  DATA_W  asynchronous tile output bus (uo_out).
- enable  in  1  when low, change detection is suppressed; the tracking register still follows the bus.
- rd_ready  in  1  consumer accepts the head record.
- rd_valid  out  1  FIFO is non-empty.
- rd_data  out  TS_W+DATA_W  head record, {ts, value}; timestamp in the MSBs.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when an event is dropped.
- drop_cnt  out  DROP_W  number of dropped events, saturating.
- clear_ovf  in  1  clears overflow and drop_cnt.

Behaviour:
- Reset, on a clk edge with rst=1:
  - Synchroniser flops s1/s2, prev, ts, FIFO pointers, count, overflow and drop_cnt all go to 0.
  - rd_valid=0.
  - rd_data content is don't-care while rd_valid=0.
  - A reset mid-operation discards all stored records.
- Synchroniser: s1<=uo_in, s2<=s1 (two flops).
- Timestamp: ts increments every cycle and wraps modulo 2^TS_W.
- Change detect: evt = enable && (s2 != prev). prev<=s2 every cycle regardless of enable.
  - prev resets to 0, so a nonzero bus after reset logs one event.
- Latency: a bus change sampled into s1 at edge N reaches s2 at N+1, is written at edge N+2, and rd_valid is high in the cycle after N+2.
- Stored timestamp: the ts value present before the write edge.
- Push and pop:
  - push = evt.
  - pop = rd_valid && rd_ready. rd_data is combinational from mem[rd_ptr] (show-ahead).
- Full, no pop:
  - Push is dropped and overflow<=1.
  - drop_cnt increments, saturating at 2^DROP_W-1.
- Full with simultaneous pop: push is accepted; count is unchanged.
- Empty with simultaneous push: no pop occurs (rd_valid=0); the record becomes visible the next cycle. No fall-through.
- rd_ready while empty: ignored.
- clear_ovf: overflow<=0 and drop_cnt<=0. If a drop happens in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- Pointers: $clog2(DEPTH) bits, wrap naturally. Full/empty are derived from count.

Optional Feature:
- Macro: UO_LOG_TS_DELTA_EN.
- Defined:
  - The stored ts field is the cycles elapsed since the previous accepted event, saturating at 2^TS_W-1.
  - The delta counter resets to 0 and restarts at 0 on each accepted push.
  - A dropped event does not restart it.
- Undefined: absolute wrapping timestamp as described in Behaviour.

Decomposition:
- Package uo_log_pkg holds:
  - localparam REC_W = TS_W+DATA_W;
  - typedef uo_rec_t as the struct {ts, value};
  - the FIFO pointer width function.
- One sub-module, uo_log_fifo: synchronous-reset show-ahead FIFO with push, pop, count and full/empty.
- Synchroniser, change detection, timestamp and overflow logic stay in the top.

Test Plan:
- Reset release with uo_in=0x00 held for 20 cycles -> rd_valid=0, count=0, overflow=0.
- uo_in changes 0x00->0x5A at the cycle where ts=10, rd_ready=0 -> one record {ts=12, 0x5A} visible; rd_valid high 3 edges after the change; count=1.
- 10 distinct changes spaced 4 cycles apart with DEPTH=8 and rd_ready=0 -> count=8, overflow=1, drop_cnt=2. Draining returns the first 8 values in order.
- With the FIFO full, assert rd_ready in the same cycle as a new event -> no drop; count stays 8; the new record lands last.
- Pulse clear_ovf in the same cycle as a full-FIFO drop -> overflow=1, drop_cnt=1. Pulse clear_ovf alone -> both 0.
- enable=0 while the bus toggles 0x01->0x02, then enable=1 with the bus steady -> no records logged. A later change 0x02->0x03 logs exactly one record with value 0x03.
